irq_capture: RTL and testbench
==============================

Name: irq_capture

Overview:
- Front-end stage that feeds the 8-to-3 priority encoder.
- Turns eight asynchronous request lines into latched, masked, rising-edge pending bits.
- Presents a frozen snapshot of them on d0..d7 so the encoder's a/b/c output stays stable while the consumer services it.
- A valid/ack handshake clears the serviced bit, using the encoder's own {a,b,c} result as the clear index.

Parameters:
- HOLDOFF, 2: idle cycles forced after each accepted ack before the next snapshot; 0 means no holdoff state.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_in  input  8  request lines; bit i feeds encoder input di.
- mask  input  8  per-bit enable; 1 = presentable.
- ack  input  1  consumer accepts the current snapshot.
- ack_idx  input  3  index being acknowledged, driven from encoder {a,b,c} (a = MSB).
- overrun_clr  input  1  clears the overrun flags.
- d0..d7  output  1 each  snapshot bits to the encoder inputs d0..d7.
- valid  output  1  snapshot on d0..d7 is live.
- pending  output  8  raw pending register, for debug.
- overrun  output  8  sticky flag per bit: a new edge arrived while that bit was already pending.

Behaviour:
- Reset (rst_n low, async): req_q, pending, overrun and snapshot = 0; d0..d7 = 0; valid = 0; state = IDLE; holdoff counter = 0. Outputs stay at these values until the first clock edge after rst_n deasserts.
- Edge detect: edge = req_in & ~req_q, registered every cycle. Level-held requests produce exactly one edge.
- Pending set: pending[i] <= 1 on edge[i], regardless of mask or state.
- Pending clear: only on an accepted ack, and only bit ack_idx.
- Same-cycle set and clear on one bit: set wins; the bit stays pending; no overrun.
- Overrun: edge[i] while pending[i] = 1 and not being cleared that cycle sets overrun[i]. Sticky. overrun_clr zeroes all bits; an overrun event in the same cycle as overrun_clr wins.
- Snapshot: d[i] = snapshot[i]. Loaded with pending & mask on IDLE->PRESENT only; frozen in all other states.
- Masked bits stay pending and are presented once unmasked.
- FSM, 3 states:
  - IDLE: valid = 0. If (pending & mask) != 0, load snapshot, go to PRESENT.
  - PRESENT: valid = 1. Accepted ack = ack = 1 and snapshot[ack_idx] = 1. On accepted ack: clear pending[ack_idx], clear snapshot, drop valid next cycle, go to HOLDOFF (or IDLE if HOLDOFF = 0). An ack whose snapshot bit is 0 is ignored and the state is held. Mask changes in PRESENT do not alter the snapshot.
  - HOLDOFF: valid = 0. Counter loads HOLDOFF-1 on entry and decrements; at 0, go to IDLE. New edges still latch during HOLDOFF.
- ack outside PRESENT is ignored.
- Latency: req_in rising, sampled at edge k, sets pending at edge k. At edge k+1, valid = 1 and the snapshot is visible. Back-to-back service: the next valid rises HOLDOFF+1 cycles after the ack edge.
- Counter width: clog2(HOLDOFF+1), minimum 1.
- Reset mid-operation: everything returns to the reset values immediately; no ack is needed afterwards.

Optional Feature:
- Macro IRQ_CAPTURE_SYNC_EN.
- Defined: req_in passes through a two-flop synchronizer (reset 0) before edge detect; request-to-valid latency grows by 2 cycles.
- Undefined: req_in goes directly to edge detect; the caller guarantees synchronous inputs.

Test Plan:
- Reset, then req_in = 8'h01 held, mask = 8'hFF -> valid = 1 two cycles later, d0 = 1, d1..d7 = 0, pending = 8'h01; holding req_in gives no second edge.
- req_in = 8'h81 in one cycle, ack with ack_idx = 3'b111 -> pending = 8'h01. After HOLDOFF = 2 idle cycles, valid = 1 with snapshot 8'h01. ack_idx = 3'b000 -> pending = 0, valid stays 0.
- In PRESENT with snapshot 8'h04, pulse req_in bit 5 -> d0..d7 unchanged, pending = 8'h24. ack_idx = 3'b101 is ignored; ack_idx = 3'b010 is accepted.
- Bit 3 pending, second rising edge on bit 3 -> overrun = 8'h08. overrun_clr -> 8'h00. Edge coinciding with the ack clear of bit 3 -> pending[3] = 1, overrun = 0.
- mask = 8'h00 with req 8'h10 -> valid stays 0, pending = 8'h10. Set mask = 8'h10 -> valid next cycle, d4 = 1.
- Assert rst_n low while in PRESENT -> valid, d0..d7, pending and overrun all 0 immediately, without waiting for a clock edge. Repeat with IRQ_CAPTURE_SYNC_EN defined -> latency is 4 cycles.

Source files
------------

// File: rtl/irq_capture.sv
// Request capture front-end for the 8-to-3 priority encoder: edge-latched pending bits,
// frozen masked snapshot on d0..d7, valid/ack service. Optional macro: IRQ_CAPTURE_SYNC_EN.
module irq_capture #(
    parameter int unsigned HOLDOFF = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req_in,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic [2:0] ack_idx,
    input  logic       overrun_clr,
    output logic       d0,
    output logic       d1,
    output logic       d2,
    output logic       d3,
    output logic       d4,
    output logic       d5,
    output logic       d6,
    output logic       d7,
    output logic       valid,
    output logic [7:0] pending,
    output logic [7:0] overrun
);

    localparam int unsigned CNT_W = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (HOLDOFF > 0) ? CNT_W'(HOLDOFF - 1) : '0;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PRESENT = 2'd1;
    localparam logic [1:0] ST_HOLDOFF = 2'd2;

    logic [7:0]       req_s;
    logic [7:0]       req_q;
    logic [7:0]       rise;
    logic [7:0]       pending_q, pending_d;
    logic [7:0]       overrun_q, overrun_d;
    logic [7:0]       snapshot_q, snapshot_d;
    logic [7:0]       clr_vec;
    logic [7:0]       ovr_evt;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

`ifdef IRQ_CAPTURE_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= req_in;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req_in;
`endif

    assign rise = req_s & ~req_q;

    // An ack only counts when it names a bit that is actually in the live snapshot.
    assign accept  = (state_q == ST_PRESENT) && ack && snapshot_q[ack_idx];
    assign clr_vec = accept ? (8'h01 << ack_idx) : 8'h00;

    // A fresh edge on a bit being cleared re-arms it without counting as an overrun.
    always_comb begin
        pending_d = (pending_q & ~clr_vec) | rise;
        ovr_evt   = rise & pending_q & ~clr_vec;
        overrun_d = (overrun_clr ? 8'h00 : overrun_q) | ovr_evt;
    end

    always_comb begin
        state_d    = state_q;
        snapshot_d = snapshot_q;
        cnt_d      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|(pending_q & mask)) begin
                    snapshot_d = pending_q & mask;
                    state_d    = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (accept) begin
                    snapshot_d = 8'h00;
                    if (HOLDOFF == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_HOLDOFF;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                snapshot_d = 8'h00;
                cnt_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q      <= 8'h00;
            pending_q  <= 8'h00;
            overrun_q  <= 8'h00;
            snapshot_q <= 8'h00;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
        end else begin
            req_q      <= req_s;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            snapshot_q <= snapshot_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign valid   = (state_q == ST_PRESENT);
    assign pending = pending_q;
    assign overrun = overrun_q;

    assign d0 = snapshot_q[0];
    assign d1 = snapshot_q[1];
    assign d2 = snapshot_q[2];
    assign d3 = snapshot_q[3];
    assign d4 = snapshot_q[4];
    assign d5 = snapshot_q[5];
    assign d6 = snapshot_q[6];
    assign d7 = snapshot_q[7];

endmodule

// File: tb/tb_irq_capture.sv
// Self-checking bench for irq_capture: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_irq_capture;

    localparam int unsigned HOLDOFF = 2;
`ifdef IRQ_CAPTURE_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_in = 8'h00;
    logic [7:0] mask = 8'h00;
    logic       ack = 1'b0;
    logic [2:0] ack_idx = 3'd0;
    logic       overrun_clr = 1'b0;
    logic       d0, d1, d2, d3, d4, d5, d6, d7;
    logic       valid;
    logic [7:0] pending;
    logic [7:0] overrun;
    logic [7:0] dvec;

    int n_checks = 0;
    int n_pass = 0;

    // Model state: what the spec says the visible registers hold.
    logic [7:0] m_pend, m_ovr, m_snap, m_reqq;
    logic [7:0] m_sync [2];
    logic       m_valid;
    int         m_gap;

    irq_capture #(.HOLDOFF(HOLDOFF)) dut (
        .clk(clk), .rst_n(rst_n), .req_in(req_in), .mask(mask), .ack(ack),
        .ack_idx(ack_idx), .overrun_clr(overrun_clr),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
        .valid(valid), .pending(pending), .overrun(overrun)
    );

    assign dvec = {d7, d6, d5, d4, d3, d2, d1, d0};

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, got timeout want finish");
        $fatal(1);
    end

    function automatic logic [24:0] obs();
        return {valid, dvec, pending, overrun};
    endfunction

    function automatic logic [24:0] mobs();
        return {m_valid, m_snap, m_pend, m_ovr};
    endfunction

    task automatic model_reset();
        m_pend = 0; m_ovr = 0; m_snap = 0; m_reqq = 0;
        m_sync[0] = 0; m_sync[1] = 0;
        m_valid = 0; m_gap = 0;
    endtask

    task automatic model_step();
        logic [7:0] rs, rise, np, no;
        logic       acc, clr;
        if (SYNC != 0) begin
            rs = m_sync[1];
            m_sync[1] = m_sync[0];
            m_sync[0] = req_in;
        end else begin
            rs = req_in;
        end
        rise = rs & ~m_reqq;
        m_reqq = rs;
        acc = m_valid && ack && m_snap[ack_idx];
        for (int i = 0; i < 8; i++) begin
            clr = acc && (int'(ack_idx) == i);
            np[i] = (m_pend[i] && !clr) || rise[i];
            no[i] = (overrun_clr ? 1'b0 : m_ovr[i]) || (rise[i] && m_pend[i] && !clr);
        end
        if (m_valid) begin
            if (acc) begin
                m_valid = 0;
                m_snap = 0;
                m_gap = HOLDOFF;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if ((m_pend & mask) != 0) begin
            m_snap = m_pend & mask;
            m_valid = 1;
        end
        m_pend = np;
        m_ovr = no;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        req_in = 0; ack = 0; ack_idx = 0; overrun_clr = 0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        #3;
        model_reset();
        n_checks++;
        if (obs() !== 25'h0) $display("FAIL reset_state: got %h want %h", obs(), 25'h0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        tick();
        n_checks++;
        if (obs() !== 25'h0) $display("FAIL reset_idle: got %h want %h", obs(), 25'h0);
        else n_pass++;
    endtask

    task automatic test_single_edge();
        do_reset();
        mask = 8'hFF;
        req_in = 8'h01;
        repeat (SYNC + 1) tick();
        n_checks++;
        if (pending !== 8'h01 || valid !== 1'b0)
            $display("FAIL single_pending: got p=%h v=%b want p=01 v=0", pending, valid);
        else n_pass++;
        tick();
        n_checks++;
        if (valid !== 1'b1 || dvec !== 8'h01)
            $display("FAIL single_valid: got v=%b d=%h want v=1 d=01", valid, dvec);
        else n_pass++;
        repeat (4) tick();
        n_checks++;
        if (obs() !== mobs() || pending !== 8'h01 || overrun !== 8'h00)
            $display("FAIL single_held: got %h want %h", obs(), mobs());
        else n_pass++;
        req_in = 8'h00;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        mask = 8'hFF;
        req_in = 8'h81;
        tick();
        req_in = 8'h00;
        repeat (SYNC + 1) tick();
        n_checks++;
        if (valid !== 1'b1 || dvec !== 8'h81)
            $display("FAIL b2b_first: got v=%b d=%h want v=1 d=81", valid, dvec);
        else n_pass++;
        ack = 1; ack_idx = 3'd7;
        tick();
        ack = 0;
        n_checks++;
        if (pending !== 8'h01 || valid !== 1'b0)
            $display("FAIL b2b_ack7: got p=%h v=%b want p=01 v=0", pending, valid);
        else n_pass++;
        for (int i = 0; i < int'(HOLDOFF); i++) begin
            tick();
            n_checks++;
            if (valid !== 1'b0) $display("FAIL b2b_holdoff: got v=%b want v=0", valid);
            else n_pass++;
        end
        tick();
        n_checks++;
        if (valid !== 1'b1 || dvec !== 8'h01 || obs() !== mobs())
            $display("FAIL b2b_second: got %h want %h", obs(), mobs());
        else n_pass++;
        ack = 1; ack_idx = 3'd0;
        tick();
        ack = 0;
        repeat (4) tick();
        n_checks++;
        if (pending !== 8'h00 || valid !== 1'b0)
            $display("FAIL b2b_drained: got p=%h v=%b want p=00 v=0", pending, valid);
        else n_pass++;
    endtask

    task automatic test_freeze();
        do_reset();
        mask = 8'hFF;
        req_in = 8'h04;
        tick();
        req_in = 8'h00;
        repeat (SYNC + 1) tick();
        req_in = 8'h20;
        tick();
        req_in = 8'h00;
        repeat (SYNC) tick();
        mask = 8'h20;
        tick();
        n_checks++;
        if (dvec !== 8'h04 || pending !== 8'h24 || valid !== 1'b1)
            $display("FAIL freeze_snap: got d=%h p=%h v=%b want d=04 p=24 v=1",
                     dvec, pending, valid);
        else n_pass++;
        ack = 1; ack_idx = 3'd5;
        tick();
        n_checks++;
        if (valid !== 1'b1 || pending !== 8'h24)
            $display("FAIL freeze_ign_ack: got v=%b p=%h want v=1 p=24", valid, pending);
        else n_pass++;
        ack_idx = 3'd2;
        tick();
        ack = 0;
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h20 || obs() !== mobs())
            $display("FAIL freeze_ack: got %h want %h", obs(), mobs());
        else n_pass++;
        mask = 8'hFF;
    endtask

    task automatic test_overrun();
        do_reset();
        mask = 8'hFF;
        for (int k = 0; k < 2; k++) begin
            req_in = 8'h08;
            tick();
            req_in = 8'h00;
            repeat (SYNC + 1) tick();
        end
        n_checks++;
        if (overrun !== 8'h08) $display("FAIL ovr_set: got %h want 08", overrun);
        else n_pass++;
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        n_checks++;
        if (overrun !== 8'h00) $display("FAIL ovr_clr: got %h want 00", overrun);
        else n_pass++;
        req_in = 8'h08;
        repeat (SYNC) tick();
        ack = 1; ack_idx = 3'd3;
        tick();
        ack = 0;
        req_in = 8'h00;
        n_checks++;
        if (pending !== 8'h08 || overrun !== 8'h00 || valid !== 1'b0)
            $display("FAIL ovr_set_wins: got p=%h o=%h v=%b want p=08 o=00 v=0",
                     pending, overrun, valid);
        else n_pass++;
        tick();
        req_in = 8'h08;
        repeat (SYNC) tick();
        overrun_clr = 1;
        tick();
        overrun_clr = 0;
        req_in = 8'h00;
        n_checks++;
        if (overrun !== 8'h08 || obs() !== mobs())
            $display("FAIL ovr_evt_wins: got %h want %h", obs(), mobs());
        else n_pass++;
    endtask

    task automatic test_mask();
        do_reset();
        mask = 8'h00;
        req_in = 8'h10;
        tick();
        req_in = 8'h00;
        repeat (SYNC + 3) tick();
        n_checks++;
        if (valid !== 1'b0 || pending !== 8'h10)
            $display("FAIL mask_hold: got v=%b p=%h want v=0 p=10", valid, pending);
        else n_pass++;
        mask = 8'h10;
        tick();
        n_checks++;
        if (valid !== 1'b1 || dvec !== 8'h10)
            $display("FAIL mask_open: got v=%b d=%h want v=1 d=10", valid, dvec);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        req_in = 8'h10;
        tick();
        req_in = 8'h00;
        repeat (SYNC + 1) tick();
        n_checks++;
        if (valid !== 1'b1 || overrun !== 8'h10)
            $display("FAIL midrst_setup: got v=%b o=%h want v=1 o=10", valid, overrun);
        else n_pass++;
        #2;
        rst_n = 0;
        #1;
        model_reset();
        n_checks++;
        if (obs() !== 25'h0) $display("FAIL midrst_async: got %h want %h", obs(), 25'h0);
        else n_pass++;
        @(negedge clk);
        rst_n = 1;
        repeat (2) tick();
        n_checks++;
        if (obs() !== 25'h0) $display("FAIL midrst_after: got %h want %h", obs(), 25'h0);
        else n_pass++;
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            req_in = 8'($urandom) & 8'($urandom) & 8'($urandom);
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            ack = 1'($urandom_range(0, 1));
            ack_idx = 3'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                for (int b = 0; b < 8; b++) if (dvec[b]) ack_idx = 3'(b);
            end
            overrun_clr = ($urandom_range(0, 15) == 0);
            tick();
            n_checks++;
            if (obs() !== mobs()) begin
                if (errs < 10)
                    $display("FAIL random_cycle%0d: got %h want %h", c, obs(), mobs());
                errs++;
            end else begin
                n_pass++;
            end
        end
        ack = 0; overrun_clr = 0; req_in = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_edge();
        test_back_to_back();
        test_freeze();
        test_overrun();
        test_mask();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
